// File: rtl/cmd_fetch.sv
// -----------------------------------------------------------------------------
// cmd_fetch: command prefetch stage between cmd_mem and the decode sequencer.
//
// The memory side walks fetch_pc and issues one request at a time to cmd_mem
// over a level request / done pulse handshake. Returned words are stored,
// tagged with their address, in a small FIFO. The consumer side hands one
// command per in_fetch request as a single-cycle out_fetch pulse. A redirect
// flushes the FIFO and restarts fetching at redirect_adr. A request that is
// still in flight is allowed to finish, but its data is dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_fetch / out_fetch  consumer request level / delivery pulse
//   cmd_out, pc_out       delivered command and its address
//   redirect              one-cycle jump request, redirect_adr = target
//   in_cmd_mem, adr_cmd   request to cmd_mem and its address
//   cmd, out_cmd_mem      returned word and done pulse from cmd_mem
//   count, empty          FIFO occupancy and empty flag
// -----------------------------------------------------------------------------
module cmd_fetch #(
    parameter int ADR_W     = 4,
    parameter int CMD_W     = 16,
    parameter int DEPTH     = 4,
    parameter int RESET_ADR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_fetch,
    output logic                       out_fetch,
    output logic [CMD_W-1:0]           cmd_out,
    output logic [ADR_W-1:0]           pc_out,
    input  logic                       redirect,
    input  logic [ADR_W-1:0]           redirect_adr,
    output logic                       in_cmd_mem,
    output logic [ADR_W-1:0]           adr_cmd,
    input  logic [CMD_W-1:0]           cmd,
    input  logic                       out_cmd_mem,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [ADR_W-1:0]     fetch_pc_r;
    logic [ADR_W-1:0]     fetch_pc_s;
    logic                 req_r;
    logic                 req_s;
    logic [ADR_W-1:0]     adr_r;
    logic [ADR_W-1:0]     adr_s;
    logic                 push_s;
    logic                 pop_s;

    logic [CMD_W-1:0]     fifo_cmd_r [DEPTH];
    logic [ADR_W-1:0]     fifo_pc_r  [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_s;
    logic                 empty_r;

    logic                 out_fetch_r;
    logic [CMD_W-1:0]     cmd_out_r;
    logic [ADR_W-1:0]     pc_out_r;

    // Memory-side next state: request issue, hold, drain and gap sequencing.
    always_comb begin
        state_s = state_r;
        req_s   = req_r;
        adr_s   = adr_r;
        push_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect) begin
                    // FIFO is flushed on this edge, so space is guaranteed.
                    state_s = ST_REQ;
                    req_s   = 1'b1;
                    adr_s   = redirect_adr;
                end else if (count_r < CNT_W'(DEPTH)) begin
                    state_s = ST_REQ;
                    req_s   = 1'b1;
                    adr_s   = fetch_pc_r;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (out_cmd_mem) begin
                    state_s = ST_GAP;
                    req_s   = 1'b0;
                    push_s  = ~redirect;
                end else if (redirect) begin
                    // Address stays put; the old request must finish first.
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (out_cmd_mem) begin
                    state_s = ST_GAP;
                    req_s   = 1'b0;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_GAP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
                adr_s   = fetch_pc_r;
            end
        endcase
    end

    // Fetch address, consumer pop and FIFO occupancy next values.
    always_comb begin
        if (redirect) begin
            fetch_pc_s = redirect_adr;
        end else if (push_s) begin
            fetch_pc_s = fetch_pc_r + ADR_W'(1);
        end else begin
            fetch_pc_s = fetch_pc_r;
        end

        // No delivery on back-to-back cycles, and none on a flushing edge.
        pop_s = in_fetch & ~empty_r & ~out_fetch_r & ~redirect;

        if (redirect) begin
            count_s = CNT_W'(0);
        end else if (push_s && !pop_s) begin
            count_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_s = count_r - CNT_W'(1);
        end else begin
            count_s = count_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Memory request outputs and fetch address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r      <= 1'b0;
            adr_r      <= ADR_W'(0);
            fetch_pc_r <= ADR_W'(RESET_ADR);
        end else begin
            req_r      <= req_s;
            adr_r      <= adr_s;
            fetch_pc_r <= fetch_pc_s;
        end
    end

    // FIFO storage: each entry holds the command and the address it came from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_cmd_r[i] <= CMD_W'(0);
                fifo_pc_r[i]  <= ADR_W'(0);
            end
        end else if (push_s) begin
            fifo_cmd_r[wr_ptr_r] <= cmd;
            fifo_pc_r[wr_ptr_r]  <= adr_r;
        end else begin
            fifo_cmd_r[wr_ptr_r] <= fifo_cmd_r[wr_ptr_r];
            fifo_pc_r[wr_ptr_r]  <= fifo_pc_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and empty flag; redirect flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            empty_r  <= 1'b1;
        end else if (redirect) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            count_r  <= count_s;
            empty_r  <= (count_s == CNT_W'(0));
        end
    end

    // Consumer outputs: one-cycle pulse, data held until the next delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_fetch_r <= 1'b0;
            cmd_out_r   <= CMD_W'(0);
            pc_out_r    <= ADR_W'(0);
        end else if (pop_s) begin
            out_fetch_r <= 1'b1;
            cmd_out_r   <= fifo_cmd_r[rd_ptr_r];
            pc_out_r    <= fifo_pc_r[rd_ptr_r];
        end else begin
            out_fetch_r <= 1'b0;
            cmd_out_r   <= cmd_out_r;
            pc_out_r    <= pc_out_r;
        end
    end

    assign out_fetch  = out_fetch_r;
    assign cmd_out    = cmd_out_r;
    assign pc_out     = pc_out_r;
    assign in_cmd_mem = req_r;
    assign adr_cmd    = adr_r;
    assign count      = count_r;
    assign empty      = empty_r;

endmodule

// File: tb/tb_cmd_fetch.sv
// -----------------------------------------------------------------------------
// tb_cmd_fetch: directed bench for cmd_fetch. A small cmd_mem model returns
// 16'h1000 + address after a programmable number of cycles; the main thread
// walks through reset, streaming, back-pressure, wrap, redirect and reset
// scenarios with hand-derived expected values.
// -----------------------------------------------------------------------------
module tb_cmd_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_fetch;
    logic        out_fetch;
    logic [15:0] cmd_out;
    logic [3:0]  pc_out;
    logic        redirect;
    logic [3:0]  redirect_adr;
    logic        in_cmd_mem;
    logic [3:0]  adr_cmd;
    logic [15:0] cmd;
    logic        out_cmd_mem;
    logic [2:0]  count;
    logic        empty;

    int n_pass  = 0;
    int n_total = 0;
    int mem_lat = 1;
    int lat_cnt = 0;

    cmd_fetch #(.ADR_W(4), .CMD_W(16), .DEPTH(4), .RESET_ADR(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_fetch     (in_fetch),
        .out_fetch    (out_fetch),
        .cmd_out      (cmd_out),
        .pc_out       (pc_out),
        .redirect     (redirect),
        .redirect_adr (redirect_adr),
        .in_cmd_mem   (in_cmd_mem),
        .adr_cmd      (adr_cmd),
        .cmd          (cmd),
        .out_cmd_mem  (out_cmd_mem),
        .count        (count),
        .empty        (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cmd_mem model: answers mem_lat cycles after the request, one-cycle done.
    initial begin
        out_cmd_mem = 1'b0;
        cmd         = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_cmd_mem = 1'b0;
                lat_cnt     = 0;
            end else if (out_cmd_mem) begin
                out_cmd_mem = 1'b0;
                lat_cnt     = 0;
            end else if (in_cmd_mem) begin
                if (lat_cnt >= mem_lat - 1) begin
                    out_cmd_mem = 1'b1;
                    cmd         = 16'h1000 + {12'h000, adr_cmd};
                    lat_cnt     = 0;
                end else begin
                    lat_cnt = lat_cnt + 1;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_fetch = 1'b0;
        redirect = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_fetch(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            got = out_fetch;
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_rise(input string tag);
        logic got;
        logic prev;
        got  = 1'b0;
        prev = in_cmd_mem;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            got  = in_cmd_mem & ~prev;
            prev = in_cmd_mem;
        end
        chk({tag, "_req"}, 32'(got), 32'd1);
    endtask

    initial begin
        int reqs;
        logic prev;
        rst_n        = 1'b0;
        in_fetch     = 1'b0;
        redirect     = 1'b0;
        redirect_adr = 4'd0;

        // ---- 1: reset values, then streaming with in_fetch held high ----
        step();
        chk("rst_out_fetch", 32'(out_fetch), 32'd0);
        chk("rst_in_cmd_mem", 32'(in_cmd_mem), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_adr_cmd", 32'(adr_cmd), 32'd0);
        chk("rst_cmd_out", 32'(cmd_out), 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        do_reset();
        mem_lat  = 1;
        in_fetch = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_fetch("stream");
            chk("stream_pc", 32'(pc_out), 32'(k));
            chk("stream_cmd", 32'(cmd_out), 32'h1000 + 32'(k));
            step();
            chk("stream_pulse_width", 32'(out_fetch), 32'd0);
        end

        // ---- 2: back-pressure, FIFO fills to 4 and requests stop ----
        do_reset();
        reqs = 0;
        prev = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (in_cmd_mem && !prev) reqs++;
            prev = in_cmd_mem;
        end
        chk("full_reqs", 32'(reqs), 32'd4);
        chk("full_count", 32'(count), 32'd4);
        chk("full_empty", 32'(empty), 32'd0);
        chk("full_no_req", 32'(in_cmd_mem), 32'd0);
        in_fetch = 1'b1;
        wait_fetch("full_first");
        chk("full_first_pc", 32'(pc_out), 32'd0);
        chk("full_first_cmd", 32'(cmd_out), 32'h1000);
        in_fetch = 1'b0;
        wait_rise("resume");
        chk("resume_adr", 32'(adr_cmd), 32'd4);

        // ---- 3: fetch from 14, address wraps 15 -> 0 ----
        do_reset();
        redirect     = 1'b1;
        redirect_adr = 4'd14;
        step();
        redirect = 1'b0;
        chk("wrap_first_adr", 32'(adr_cmd), 32'd14);
        in_fetch = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_fetch("wrap");
            chk("wrap_pc", 32'(pc_out), (32'd14 + 32'(k)) % 32'd16);
            chk("wrap_cmd", 32'(cmd_out), 32'h1000 + ((32'd14 + 32'(k)) % 32'd16));
        end

        // ---- 4: redirect to 9 with a slow memory in flight ----
        do_reset();
        mem_lat  = 4;
        in_fetch = 1'b1;
        step();
        chk("slow_req_up", 32'(in_cmd_mem), 32'd1);
        redirect     = 1'b1;
        redirect_adr = 4'd9;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!in_cmd_mem) break;
            chk("drain_adr_hold", 32'(adr_cmd), 32'd0);
            chk("drain_no_fetch", 32'(out_fetch), 32'd0);
            step();
        end
        chk("drain_done", 32'(in_cmd_mem), 32'd0);
        chk("drain_dropped", 32'(count), 32'd0);
        wait_rise("after_drain");
        chk("after_drain_adr", 32'(adr_cmd), 32'd9);
        wait_fetch("after_drain");
        chk("after_drain_pc", 32'(pc_out), 32'd9);
        chk("after_drain_cmd", 32'(cmd_out), 32'h1009);

        // ---- 5: redirect on the same edge as out_cmd_mem, 2 buffered ----
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 40 && count != 3'd2; i++) step();
        chk("same_edge_count2", 32'(count), 32'd2);
        for (int i = 0; i < 10 && !in_cmd_mem; i++) step();
        @(negedge clk);
        #1;
        chk("same_edge_done", 32'(out_cmd_mem), 32'd1);
        redirect     = 1'b1;
        redirect_adr = 4'd11;
        step();
        redirect = 1'b0;
        chk("same_edge_flush", 32'(count), 32'd0);
        chk("same_edge_empty", 32'(empty), 32'd1);
        chk("same_edge_gap", 32'(in_cmd_mem), 32'd0);
        wait_rise("same_edge");
        chk("same_edge_adr", 32'(adr_cmd), 32'd11);
        chk("same_edge_dropped", 32'(count), 32'd0);
        in_fetch = 1'b1;
        wait_fetch("same_edge");
        chk("same_edge_pc", 32'(pc_out), 32'd11);
        chk("same_edge_cmd", 32'(cmd_out), 32'h100B);

        // ---- 6: asynchronous reset mid-request with 3 buffered ----
        do_reset();
        mem_lat = 4;
        for (int i = 0; i < 60 && count != 3'd3; i++) step();
        chk("areset_count3", 32'(count), 32'd3);
        for (int i = 0; i < 10 && !in_cmd_mem; i++) step();
        chk("areset_in_req", 32'(in_cmd_mem), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_req", 32'(in_cmd_mem), 32'd0);
        chk("areset_out_fetch", 32'(out_fetch), 32'd0);
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_empty", 32'(empty), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        wait_rise("areset");
        chk("areset_adr", 32'(adr_cmd), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cmd_fetch.md
Name: cmd_fetch

Overview:
- Command prefetch stage between `cmd_mem` and the CPU decode sequencer.
- Walks a fetch address and issues requests to `cmd_mem` using its `in_cmd_mem`/`out_cmd_mem` request/done handshake.
- Buffers returned commands, tagged with their address, in a small FIFO.
- Hands commands to the sequencer one at a time over an `in_fetch`/`out_fetch` handshake.
- Supports a redirect (jump) that flushes buffered and in-flight commands.

Parameters:
- `ADR_W`, 4: command address width; fetch address wraps modulo 2^ADR_W.
- `CMD_W`, 16: command word width.
- `DEPTH`, 4: FIFO entries, power of two, minimum 2.
- `RESET_ADR`, 0: fetch address loaded at reset.

Ports:
- `clk`  in  1  — single clock, all logic on posedge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_fetch`  in  1  — consumer request; level, held until `out_fetch` is seen.
- `out_fetch`  out  1  — one-cycle pulse; `cmd_out`/`pc_out` valid in this cycle.
- `cmd_out`  out  CMD_W  — delivered command.
- `pc_out`  out  ADR_W  — address of the delivered command.
- `redirect`  in  1  — one-cycle pulse; restart fetch at `redirect_adr`.
- `redirect_adr`  in  ADR_W  — new fetch address.
- `in_cmd_mem`  out  1  — request to `cmd_mem`.
- `adr_cmd`  out  ADR_W  — request address, stable while `in_cmd_mem` is high.
- `cmd`  in  CMD_W  — command word from `cmd_mem`, valid when `out_cmd_mem` is high.
- `out_cmd_mem`  in  1  — `cmd_mem` done.
- `count`  out  $clog2(DEPTH+1)  — FIFO occupancy.
- `empty`  out  1  — `count == 0`.

Behaviour:

Reset:
- `rst_n` low asynchronously clears `out_fetch`, `cmd_out`, `pc_out`, `in_cmd_mem`, `adr_cmd` and `count`.
- Reset sets `empty` = 1, fetch_pc = `RESET_ADR` and the FSM to IDLE.
- Reset mid-request abandons the request; `in_cmd_mem` drops immediately.

Memory-side FSM (IDLE, REQ, DRAIN, GAP):
- IDLE: if `count` < DEPTH, go to REQ, registering `in_cmd_mem` = 1 and `adr_cmd` = fetch_pc.
- REQ: hold `in_cmd_mem` and `adr_cmd`. On `out_cmd_mem` = 1:
  - push {`cmd`, `adr_cmd`} into the FIFO;
  - fetch_pc <= fetch_pc + 1 (wraps 2^ADR_W-1 -> 0);
  - `in_cmd_mem` <= 0; go to GAP.
- GAP: one cycle with `in_cmd_mem` low, so the memory sees the request drop, then go to IDLE. Sustained rate is one command per 3 cycles when memory answers in 1 cycle.
- DRAIN: entered on redirect while in REQ without `out_cmd_mem`.
  - Hold the old request until `out_cmd_mem`, then discard the data (no push) and go to GAP.
  - Address must not change mid-request.

FIFO and admission:
- A request is issued only when there is space: IDLE requires `count` < DEPTH. Because an in-flight request can always complete, the FIFO never overflows.

Consumer side:
- Delivery condition at a posedge: `in_fetch` = 1, FIFO non-empty, `out_fetch` currently 0 and no `redirect`.
- On delivery: `out_fetch` <= 1, `cmd_out`/`pc_out` <= FIFO head, pop.
- Otherwise `out_fetch` <= 0, so it is always a single-cycle pulse and never asserted on consecutive cycles.
- `cmd_out`/`pc_out` hold their value until the next delivery.
- Latency: a command pushed at edge t can be delivered at edge t+1 at the earliest (no bypass).
- `in_fetch` with an empty FIFO waits, with no timeout.

Simultaneous events and redirect:
- Push and pop on the same edge: `count` is unchanged.
- `redirect` has priority over everything and takes effect at that edge:
  - FIFO flushed (`count` <= 0, no delivery that edge);
  - fetch_pc <= `redirect_adr`.
- Redirect effect on the memory FSM:
  - IDLE/GAP: next request uses `redirect_adr`.
  - REQ with `out_cmd_mem` = 1 on the same edge: response discarded, go to GAP.
  - REQ without `out_cmd_mem`: go to DRAIN.
  - DRAIN: remain in DRAIN; the latest `redirect_adr` wins.
- An `out_fetch` pulse already high during the redirect cycle stands; that command was already delivered.

Test Plan:
1. Reset, `cmd_mem` holding word k = 16'h1000+k, `out_cmd_mem` one cycle after `in_cmd_mem`, `in_fetch` held high -> deliveries `pc_out` 0,1,2,… with `cmd_out` 16'h1000,16'h1001,…, each `out_fetch` exactly one cycle wide.
2. `in_fetch` held low -> exactly 4 requests issued; `count` = 4; `in_cmd_mem` stays 0 afterwards; first later `in_fetch` returns `pc_out` 0 and fetching resumes at address 4.
3. Fetch from address 14 -> `pc_out` sequence 14, 15, 0, 1 (wrap).
4. Redirect to 9 while `in_cmd_mem` is high, memory answering 3 cycles late -> `adr_cmd` unchanged until `out_cmd_mem`; that word is dropped; next request `adr_cmd` = 9; first delivery `pc_out` = 9; no stale command delivered.
5. Redirect on the same edge as `out_cmd_mem` and with 2 entries buffered -> `count` = 0, response dropped, next request address = `redirect_adr`.
6. `rst_n` pulsed low mid-REQ with 3 entries buffered -> `in_cmd_mem`, `out_fetch`, `count` = 0 immediately; after release the first request is at `RESET_ADR`.
